mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/rv_pkg.sv | 55 +++++
 rtl/rr_arb2.sv | 37 +++
 rtl/mem_arb.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings and helpers for the byte-serial memory arbiter.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  function automatic logic [2:0] size_bytes(input size_e sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Illegal size counts as misaligned so both take the same error path.
  function automatic logic misaligned(input size_e sz, input logic [1:0] lsb);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      SZ_WORD: bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input size_e sz, input logic uns,
                                                  input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] r;
    case (sz)
      SZ_BYTE: r = {{24{raw[7] & ~uns}}, raw[7:0]};
      SZ_HALF: r = {{16{raw[15] & ~uns}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the port not granted last wins a tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_f_i,
  input  logic req_d_i,
  output logic gnt_f_c,
  output logic gnt_d_c
);

  logic last_d_q, last_d_d;  // 1: data port won the most recent grant

  always_comb begin
    gnt_f_c  = 1'b0;
    gnt_d_c  = 1'b0;
    last_d_d = last_d_q;
    if (en_i) begin
      gnt_d_c = req_d_i & (~req_f_i | ~last_d_q);
      gnt_f_c = req_f_i & (~req_d_i | last_d_q);
    end
    if (gnt_d_c) begin
      last_d_d = 1'b1;
    end else if (gnt_f_c) begin
      last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Fetch/data port arbiter onto a byte-wide memory: one request at a time,
// sequenced byte by byte, little-endian, with load extension and alignment errors.
module mem_arb
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_resp,
  output logic [XLEN-1:0]   f_rdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_resp,
  output logic              d_err,
  output logic [XLEN-1:0]   d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic              port_q, port_d;  // 1: data port owns the request
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   buf_q, buf_d;

  logic              f_resp_q, f_resp_d;
  logic [XLEN-1:0]   f_rdata_q, f_rdata_d;
  logic              d_resp_q, d_resp_d;
  logic              d_err_q, d_err_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              arb_en, gnt_f, gnt_d;
  logic [ADDR_W-1:0] acc_addr;
  size_e             acc_size;
  logic              acc_err;
  logic [2:0]        n_bytes, nxt_cnt;
  logic [1:0]        cap_idx;

  assign arb_en = (state_q == ST_IDLE) & ~rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (arb_en),
    .req_f_i (f_valid),
    .req_d_i (d_valid),
    .gnt_f_c (gnt_f),
    .gnt_d_c (gnt_d)
  );

  assign f_ready   = gnt_f;
  assign d_ready   = gnt_d;
  assign f_resp    = f_resp_q;
  assign f_rdata   = f_rdata_q;
  assign d_resp    = d_resp_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

  // Memory command is registered: each state computes the command for the next cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    port_d      = port_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    f_resp_d    = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_resp_d    = 1'b0;
    d_err_d     = d_err_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    acc_addr = gnt_d ? d_addr : f_addr;
    acc_size = gnt_d ? size_e'(d_size) : SZ_WORD;
    acc_err  = misaligned(acc_size, acc_addr[1:0]);
    n_bytes  = size_bytes(size_q);
    nxt_cnt  = cnt_q + 3'd1;
    cap_idx  = 2'(cnt_q - 3'd1);

    case (state_q)
      ST_IDLE: begin
        if (gnt_f | gnt_d) begin
          addr_d  = acc_addr;
          size_d  = acc_size;
          we_d    = gnt_d & d_we;
          uns_d   = gnt_d & d_unsigned;
          port_d  = gnt_d;
          wdata_d = d_wdata;
          buf_d   = '0;
          cnt_d   = 3'd0;
          if (acc_err) begin
            state_d = ST_RESP;
            if (gnt_d) begin
              d_resp_d  = 1'b1;
              d_err_d   = 1'b1;
              d_rdata_d = '0;
            end else begin
              f_resp_d  = 1'b1;
              f_rdata_d = '0;
            end
          end else if (gnt_d & d_we) begin
            state_d     = ST_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = acc_addr;
            mem_wdata_d = d_wdata[BYTE_W-1:0];
          end else begin
            state_d    = ST_RD;
            mem_re_d   = 1'b1;
            mem_addr_d = acc_addr;
          end
        end
      end

      // Byte k is issued at cnt==k and arrives at cnt==k+1.
      ST_RD: begin
        cnt_d = nxt_cnt;
        if (cnt_q != 3'd0) begin
          buf_d[{cap_idx, 3'b000} +: BYTE_W] = mem_rdata;
        end
        if (cnt_q == n_bytes) begin
          state_d = ST_RESP;
          if (port_q) begin
            d_resp_d  = 1'b1;
            d_err_d   = 1'b0;
            d_rdata_d = load_extend(size_q, uns_q, buf_d);
          end else begin
            f_resp_d  = 1'b1;
            f_rdata_d = buf_d;
          end
        end else if (nxt_cnt < n_bytes) begin
          mem_re_d   = 1'b1;
          mem_addr_d = addr_q + ADDR_W'(nxt_cnt);
        end
      end

      ST_WR: begin
        cnt_d = nxt_cnt;
        if (nxt_cnt < n_bytes) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q + ADDR_W'(nxt_cnt);
          mem_wdata_d = wdata_q[{nxt_cnt[1:0], 3'b000} +: BYTE_W];
        end else begin
          state_d  = ST_RESP;
          d_resp_d = 1'b1;
          d_err_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      port_q      <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      f_resp_q    <= 1'b0;
      f_rdata_q   <= '0;
      d_resp_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      port_q      <= port_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      f_resp_q    <= f_resp_d;
      f_rdata_q   <= f_rdata_d;
      d_resp_q    <= d_resp_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: transaction-level schedule model checked every cycle, plus directed cases.
module tb_mem_arb;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NCYC   = 8192;
  localparam int unsigned MEM_N  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0;
  logic        f_ready;
  logic [31:0] f_addr = '0;
  logic        f_resp;
  logic [31:0] f_rdata;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_resp;
  logic        d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  mem_arb #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .f_valid    (f_valid),
    .f_ready    (f_ready),
    .f_addr     (f_addr),
    .f_resp     (f_resp),
    .f_rdata    (f_rdata),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_resp     (d_resp),
    .d_err      (d_err),
    .d_rdata    (d_rdata),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Byte memory seen by the DUT; reads return the cycle after mem_re.
  logic [7:0] env_mem [MEM_N];
  logic [7:0] ref_mem [MEM_N];

  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= env_mem[mem_addr[9:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle events, filled in at acceptance time.
  bit        exp_re [NCYC];
  bit        exp_we [NCYC];
  bit [31:0] exp_ma [NCYC];
  bit [7:0]  exp_mw [NCYC];
  bit        exp_fr [NCYC];
  bit [31:0] exp_fv [NCYC];
  bit        exp_dr [NCYC];
  bit        exp_de [NCYC];
  bit        exp_du [NCYC];
  bit [31:0] exp_dv [NCYC];

  int          cyc      = 0;
  int          m_free   = 0;
  bit          m_last_d = 1'b0;
  logic [31:0] m_frd    = '0;
  logic [31:0] m_drd    = '0;
  logic        m_derr   = 1'b0;
  bit          model_on = 1'b0;

  task automatic accept(input bit is_d);
    logic [31:0] a;
    logic [31:0] ak;
    logic [31:0] v;
    logic [1:0]  sz;
    int          n;
    bit          we;
    bit          uns;
    bit          err;
    a   = is_d ? d_addr : f_addr;
    sz  = is_d ? d_size : 2'd2;
    we  = is_d && d_we;
    uns = is_d && d_unsigned;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    if (n == 0) err = 1'b1;
    else        err = ((int'(a[1:0]) % n) != 0);
    m_last_d = is_d;
    if (err) begin
      if (is_d) begin
        exp_dr[cyc+1] = 1'b1; exp_de[cyc+1] = 1'b1;
        exp_du[cyc+1] = 1'b1; exp_dv[cyc+1] = '0;
      end else begin
        exp_fr[cyc+1] = 1'b1; exp_fv[cyc+1] = '0;
      end
      m_free = cyc + 2;
    end else if (we) begin
      for (int k = 0; k < n; k++) begin
        exp_we[cyc+1+k] = 1'b1;
        exp_ma[cyc+1+k] = a + 32'(k);
        exp_mw[cyc+1+k] = 8'(d_wdata >> (8 * k));
      end
      exp_dr[cyc+n+1] = 1'b1; exp_de[cyc+n+1] = 1'b0; exp_du[cyc+n+1] = 1'b0;
      m_free = cyc + n + 2;
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        exp_re[cyc+1+k] = 1'b1;
        exp_ma[cyc+1+k] = ak;
        v = v | (32'(ref_mem[ak[9:0]]) << (8 * k));
      end
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      if (is_d) begin
        exp_dr[cyc+n+2] = 1'b1; exp_de[cyc+n+2] = 1'b0;
        exp_du[cyc+n+2] = 1'b1; exp_dv[cyc+n+2] = v;
      end else begin
        exp_fr[cyc+n+2] = 1'b1; exp_fv[cyc+n+2] = v;
      end
      m_free = cyc + n + 3;
    end
  endtask

  // Compare process: one model step and full output check per cycle.
  always @(negedge clk) begin
    if (model_on) begin
      bit idle, gf, gd;
      idle = (cyc >= m_free) && !rst;
      gd   = idle && d_valid && (!f_valid || !m_last_d);
      gf   = idle && f_valid && (!d_valid || m_last_d);
      check("f_ready", 32'(f_ready), 32'(gf));
      check("d_ready", 32'(d_ready), 32'(gd));
      check("mem_re", 32'(mem_re), 32'(exp_re[cyc]));
      check("mem_we", 32'(mem_we), 32'(exp_we[cyc]));
      if (exp_re[cyc] || exp_we[cyc]) check("mem_addr", mem_addr, exp_ma[cyc]);
      if (exp_we[cyc]) begin
        check("mem_wdata", 32'(mem_wdata), 32'(exp_mw[cyc]));
        ref_mem[exp_ma[cyc][9:0]] = exp_mw[cyc];
      end
      check("f_resp", 32'(f_resp), 32'(exp_fr[cyc]));
      check("d_resp", 32'(d_resp), 32'(exp_dr[cyc]));
      if (exp_fr[cyc]) m_frd = exp_fv[cyc];
      if (exp_dr[cyc]) begin
        m_derr = exp_de[cyc];
        if (exp_du[cyc]) m_drd = exp_dv[cyc];
      end
      check("f_rdata", f_rdata, m_frd);
      check("d_rdata", d_rdata, m_drd);
      check("d_err", 32'(d_err), 32'(m_derr));
      if (rst) begin
        for (int i = cyc + 1; i <= cyc + 8; i++) begin
          exp_re[i] = 1'b0; exp_we[i] = 1'b0; exp_fr[i] = 1'b0; exp_dr[i] = 1'b0;
        end
        m_free = cyc + 1; m_last_d = 1'b0;
        m_frd = '0; m_drd = '0; m_derr = 1'b0;
      end else if (gf || gd) begin
        accept(gd);
      end
      cyc++;
    end
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    env_mem[a[9:0]] <= v;
    ref_mem[a[9:0]] = v;
  endtask

  task automatic reset_dut();
    rst = 1'b1; f_valid = 1'b1; d_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_f_ready", 32'(f_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_f_resp", 32'(f_resp), 32'd0);
    check("rst_d_resp", 32'(d_resp), 32'd0);
    check("rst_f_rdata", f_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; f_valid = 1'b0; d_valid = 1'b0;
  endtask

  // One request on one port; returns response latency (-1 on timeout) and strobe counts.
  task automatic issue(input bit is_d, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output int n_re, output int n_we, output bit rdy);
    f_valid = !is_d; d_valid = is_d;
    f_addr = addr; d_addr = addr; d_we = we; d_size = sz; d_unsigned = uns; d_wdata = wd;
    @(negedge clk);
    rdy = is_d ? d_ready : f_ready;
    @(posedge clk); #1;
    f_valid = 1'b0; d_valid = 1'b0;
    lat = -1; n_re = 0; n_we = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      n_re += int'(mem_re);
      n_we += int'(mem_we);
      if (is_d ? d_resp : f_resp) lat = i;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_re, n_we, ngr, nresp;
    bit rdy;
    logic [3:0] order;
    logic [7:0] rb;

    for (int i = 0; i < int'(MEM_N); i++) begin
      rb = 8'($urandom);
      env_mem[i] <= rb;
      ref_mem[i] = rb;
    end
    @(posedge clk); #1;
    model_on = 1'b1;
    reset_dut();

    // Fetch of the word at 0x100.
    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, n_re, n_we, rdy);
    check("fetch_ready", 32'(rdy), 32'd1);
    check("fetch_latency", 32'(lat), 32'd6);
    check("fetch_re_count", 32'(n_re), 32'd4);
    check("fetch_rdata", f_rdata, 32'h00100013);
    check("model_fetch", m_frd, 32'h00100013);

    // Signed and unsigned byte load of 0x80.
    poke(32'h201, 8'h80);
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h201, 32'h0, lat, n_re, n_we, rdy);
    check("lb_latency", 32'(lat), 32'd3);
    check("lb_rdata", d_rdata, 32'hFFFFFF80);
    check("model_lb", m_drd, 32'hFFFFFF80);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h201, 32'h0, lat, n_re, n_we, rdy);
    check("lbu_rdata", d_rdata, 32'h00000080);
    check("lbu_re_count", 32'(n_re), 32'd1);

    // Half store of 0xBEEF.
    issue(1'b1, 1'b1, 2'd1, 1'b0, 32'h300, 32'h0000BEEF, lat, n_re, n_we, rdy);
    check("sh_latency", 32'(lat), 32'd3);
    check("sh_we_count", 32'(n_we), 32'd2);
    check("sh_err", 32'(d_err), 32'd0);
    check("sh_byte0", 32'(env_mem[10'h300]), 32'h000000EF);
    check("sh_byte1", 32'(env_mem[10'h301]), 32'h000000BE);

    // Misaligned word load.
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h302, 32'h0, lat, n_re, n_we, rdy);
    check("lw_mis_latency", 32'(lat), 32'd1);
    check("lw_mis_err", 32'(d_err), 32'd1);
    check("lw_mis_re_count", 32'(n_re), 32'd0);

    // Misaligned fetch: error shows as f_rdata=0, d_err untouched.
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, lat, n_re, n_we, rdy);
    check("fetch_mis_latency", 32'(lat), 32'd1);
    check("fetch_mis_rdata", f_rdata, 32'h0);
    check("fetch_mis_d_err", 32'(d_err), 32'd1);

    // Word store aborted by reset two cycles after acceptance.
    poke(32'h380, 8'h00); poke(32'h381, 8'h00); poke(32'h382, 8'h00); poke(32'h383, 8'h00);
    d_valid = 1'b1; d_we = 1'b1; d_size = 2'd2; d_unsigned = 1'b0;
    d_addr = 32'h380; d_wdata = 32'h11223344;
    @(negedge clk);
    check("sw_ready", 32'(d_ready), 32'd1);
    nresp = 0;
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(negedge clk); nresp += int'(d_resp);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); nresp += int'(d_resp);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h381, 32'h0, lat, n_re, n_we, rdy);
    check("abort_no_resp", 32'(nresp), 32'd0);
    check("abort_idle_ready", 32'(rdy), 32'd1);
    check("abort_byte1", d_rdata, 32'h00000033);
    check("abort_byte0", 32'(env_mem[10'h380]), 32'h00000044);
    check("abort_byte2", 32'(env_mem[10'h382]), 32'h00000000);
    check("abort_byte3", 32'(env_mem[10'h383]), 32'h00000000);

    // Both ports held valid from reset: grants alternate starting with data.
    reset_dut();
    f_valid = 1'b1; f_addr = 32'h100;
    d_valid = 1'b1; d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b1; d_addr = 32'h201;
    ngr = 0; order = '0;
    for (int i = 0; i < 60 && ngr < 4; i++) begin
      @(negedge clk);
      if (d_ready || f_ready) begin
        order = {order[2:0], d_ready};
        ngr++;
      end
      @(posedge clk); #1;
    end
    f_valid = 1'b0; d_valid = 1'b0;
    check("tie_grant_count", 32'(ngr), 32'd4);
    check("tie_grant_order", 32'(order), 32'b1010);
    repeat (10) begin @(posedge clk); #1; end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      f_valid    = ($urandom_range(0, 99) < 40);
      d_valid    = ($urandom_range(0, 99) < 50);
      d_we       = 1'($urandom_range(0, 1));
      d_size     = 2'($urandom_range(0, 3));
      d_unsigned = 1'($urandom_range(0, 1));
      d_addr     = $urandom;
      if ($urandom_range(0, 3) != 0) d_addr[1:0] = 2'b00;
      f_addr     = $urandom;
      if ($urandom_range(0, 3) != 0) f_addr[1:0] = 2'b00;
      d_wdata    = $urandom;
      rst        = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    f_valid = 1'b0; d_valid = 1'b0; rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
